// File: rtl/subbytes_scheduler_pkg.sv
// Shared AES constants for the time-multiplexed SubBytes engine:
// FSM encodings, grant identifiers and GF(2^8) S-box arithmetic.
package subbytes_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_BUSY = 3'd1,
        S_DONE = 3'd2,
        K_BUSY = 3'd3,
        K_DONE = 3'd4
    } state_e;

    typedef enum logic {
        GNT_STATE = 1'b0,
        GNT_KEY   = 1'b1
    } grant_e;

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox_byte(logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]}
                 ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/subbytes_scheduler_if.sv
// Request/result handshakes of the shared SubBytes engine:
// a 128-bit state channel and a 32-bit key-word channel.
interface subbytes_scheduler_if;
    logic         st_valid;
    logic         st_ready;
    logic [127:0] st_in;
    logic         st_out_valid;
    logic         st_out_ready;
    logic [127:0] st_out;
    logic         kw_valid;
    logic         kw_ready;
    logic [31:0]  kw_in;
    logic         kw_out_valid;
    logic         kw_out_ready;
    logic [31:0]  kw_out;

    modport master (
        output st_valid, st_in, st_out_ready,
        output kw_valid, kw_in, kw_out_ready,
        input  st_ready, st_out_valid, st_out,
        input  kw_ready, kw_out_valid, kw_out
    );

    modport slave (
        input  st_valid, st_in, st_out_ready,
        input  kw_valid, kw_in, kw_out_ready,
        output st_ready, st_out_valid, st_out,
        output kw_ready, kw_out_valid, kw_out
    );
endinterface

// File: rtl/sbox.sv
// Single AES S-box byte substitution.
// Computed as inverse plus affine map rather than a lookup table.
module sbox
    import subbytes_scheduler_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    assign y = sbox_byte(a);
endmodule

// File: rtl/sub_word.sv
// 32-bit SubWord: four S-boxes side by side.
// This is the only substitution logic in the scheduler.
module sub_word (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    for (genvar g = 0; g < 4; g++) begin : g_sb
        sbox u_sbox (
            .a (din[8*g +: 8]),
            .y (dout[8*g +: 8])
        );
    end
endmodule

// File: rtl/subbytes_scheduler.sv
// Time-multiplexed SubBytes engine: one 32-bit slice shared by the
// round datapath (4 words per op) and key expansion (1 word per op).
module subbytes_scheduler
    import subbytes_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    subbytes_scheduler_if.slave   bus,
    output logic                  busy
);
    state_e       state_q, state_d;
    grant_e       gnt_q, gnt_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] st_buf_q, st_buf_d;
    logic [127:0] st_res_q, st_res_d;
    logic [31:0]  kw_buf_q, kw_buf_d;
    logic [31:0]  kw_res_q, kw_res_d;
    logic         st_vld_q, kw_vld_q, busy_q;
    logic [31:0]  sub_in, sub_out;
    logic         idle, st_acc, kw_acc;

    // Gated by rst_n so readies read 0 while reset is held.
    assign idle = rst_n & (state_q == IDLE);
    assign bus.st_ready = idle & (~bus.kw_valid | (gnt_q == GNT_KEY));
    assign bus.kw_ready = idle & (~bus.st_valid | (gnt_q == GNT_STATE));
    assign st_acc = bus.st_valid & bus.st_ready;
    assign kw_acc = bus.kw_valid & bus.kw_ready;

    assign sub_in = (state_q == K_BUSY) ? kw_buf_q
                                        : st_buf_q[{cnt_q, 5'd0} +: 32];

    sub_word u_sub_word (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        st_buf_d = st_buf_q;
        st_res_d = st_res_q;
        kw_buf_d = kw_buf_q;
        kw_res_d = kw_res_q;
        unique case (state_q)
            IDLE: begin
                if (st_acc) begin
                    st_buf_d = bus.st_in;
                    cnt_d    = 2'd0;
                    gnt_d    = GNT_STATE;
                    state_d  = S_BUSY;
                end else if (kw_acc) begin
                    kw_buf_d = bus.kw_in;
                    gnt_d    = GNT_KEY;
                    state_d  = K_BUSY;
                end
            end
            S_BUSY: begin
                st_res_d[{cnt_q, 5'd0} +: 32] = sub_out;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = S_DONE;
            end
            S_DONE: if (bus.st_out_ready) state_d = IDLE;
            K_BUSY: begin
                kw_res_d = sub_out;
                state_d  = K_DONE;
            end
            K_DONE: if (bus.kw_out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= GNT_KEY;
            cnt_q    <= 2'd0;
            st_buf_q <= '0;
            st_res_q <= '0;
            kw_buf_q <= '0;
            kw_res_q <= '0;
            st_vld_q <= 1'b0;
            kw_vld_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            st_buf_q <= st_buf_d;
            st_res_q <= st_res_d;
            kw_buf_q <= kw_buf_d;
            kw_res_q <= kw_res_d;
            st_vld_q <= (state_d == S_DONE);
            kw_vld_q <= (state_d == K_DONE);
            busy_q   <= (state_d != IDLE);
        end
    end

    assign bus.st_out_valid = st_vld_q;
    assign bus.kw_out_valid = kw_vld_q;
    assign bus.st_out       = st_res_q;
    assign bus.kw_out       = kw_res_q;
    assign busy             = busy_q;
endmodule

// File: tb/tb_subbytes_scheduler.sv
// Scoreboard bench for subbytes_scheduler: requesters push expected
// results, a monitor pops them on each output handshake.
module tb_subbytes_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    subbytes_scheduler_if bus ();

    subbytes_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] V1  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] E1  = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [127:0] VF  = {128{1'b1}};
    localparam logic [127:0] EF  = {16{8'h16}};
    localparam logic [31:0]  K1  = 32'hcf4f3c09;
    localparam logic [31:0]  KE1 = 32'h8a84eb01;
    localparam logic [31:0]  K0  = 32'h00000000;
    localparam logic [31:0]  KE0 = 32'h63636363;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] st_q[$];
    logic [31:0]  kw_q[$];
    logic [7:0]   gq[$];

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected completion", nm);
    endtask

    task automatic send_st(input logic [127:0] d, input logic [127:0] e,
                           input bit push);
        int n = 0;
        @(negedge clk);
        bus.st_in = d;
        bus.st_valid = 1'b1;
        #1;
        while (!bus.st_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            fail_now("st_accept");
            bus.st_valid = 1'b0;
        end else begin
            if (push) st_q.push_back(e);
            gq.push_back("S");
            @(posedge clk);
            #1;
            bus.st_valid = 1'b0;
            bus.st_in = ~d;
        end
    endtask

    task automatic send_kw(input logic [31:0] d, input logic [31:0] e);
        int n = 0;
        @(negedge clk);
        bus.kw_in = d;
        bus.kw_valid = 1'b1;
        #1;
        while (!bus.kw_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            fail_now("kw_accept");
            bus.kw_valid = 1'b0;
        end else begin
            kw_q.push_back(e);
            gq.push_back("K");
            @(posedge clk);
            #1;
            bus.kw_valid = 1'b0;
            bus.kw_in = ~d;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (st_q.size() == 0 && kw_q.size() == 0 && !busy) break;
            n++;
        end
        if (n >= 300) fail_now("drain");
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.st_out_valid && bus.st_out_ready) begin
                if (st_q.size() == 0) fail_now("st_unexpected");
                else check("st_out", bus.st_out, st_q.pop_front());
            end
            if (bus.kw_out_valid && bus.kw_out_ready) begin
                if (kw_q.size() == 0) fail_now("kw_unexpected");
                else check("kw_out", {96'd0, bus.kw_out}, {96'd0, kw_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.st_valid = 1'b0;
        bus.st_in = '0;
        bus.st_out_ready = 1'b1;
        bus.kw_valid = 1'b0;
        bus.kw_in = '0;
        bus.kw_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.st_valid = 1'b1;
        bus.kw_valid = 1'b1;
        #1;
        check("rst_st_ready", bus.st_ready, 0);
        check("rst_kw_ready", bus.kw_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_st_vld", bus.st_out_valid, 0);
        check("rst_st_out", bus.st_out, 0);
        check("rst_kw_out", bus.kw_out, 0);
        bus.st_valid = 1'b0;
        bus.kw_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Tie right after reset: state first, then key.
        gq.delete();
        fork
            send_st(V1, E1, 1'b1);
            send_kw(K1, KE1);
        join
        wait_idle();
        check("tie_count", gq.size(), 2);
        if (gq.size() == 2) begin
            check("tie_first", gq[0], "S");
            check("tie_second", gq[1], "K");
        end

        // State only: latency, busy, then backpressure.
        bus.st_out_ready = 1'b0;
        send_st(V1, E1, 1'b1);
        check("busy_e0", busy, 1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check("lat_wait", bus.st_out_valid, 0);
            check("busy_run", busy, 1);
        end
        @(posedge clk);
        #1;
        check("lat_e4", bus.st_out_valid, 1);
        bus.st_valid = 1'b1;
        bus.kw_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_data", bus.st_out, E1);
            check("bp_valid", bus.st_out_valid, 1);
            check("bp_st_ready", bus.st_ready, 0);
            check("bp_kw_ready", bus.kw_ready, 0);
        end
        bus.st_valid = 1'b0;
        bus.kw_valid = 1'b0;
        bus.st_out_ready = 1'b1;
        wait_idle();

        // Key only: one-edge latency.
        send_kw(K1, KE1);
        @(posedge clk);
        #1;
        check("kw_lat", bus.kw_out_valid, 1);
        check("kw_direct", bus.kw_out, KE1);
        wait_idle();
        send_kw(K0, KE0);
        wait_idle();

        // Both requesters back-to-back four times.
        gq.delete();
        fork
            for (int i = 0; i < 4; i++) send_st(i[0] ? VF : V1, i[0] ? EF : E1, 1'b1);
            for (int i = 0; i < 4; i++) send_kw(i[0] ? K0 : K1, i[0] ? KE0 : KE1);
        join
        wait_idle();
        check("alt_count", gq.size(), 8);
        for (int i = 0; i < gq.size() && i < 8; i++)
            check("alt_grant", gq[i], i[0] ? "K" : "S");

        // Reset after word 1 of a state op.
        send_st(VF, EF, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.st_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_st_ready", bus.st_ready, 0);
        check("mid_kw_ready", bus.kw_ready, 0);
        check("mid_busy", busy, 0);
        check("mid_st_vld", bus.st_out_valid, 0);
        check("mid_kw_vld", bus.kw_out_valid, 0);
        check("mid_st_out", bus.st_out, 0);
        check("mid_kw_out", bus.kw_out, 0);
        bus.st_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_st(VF, EF, 1'b1);
        wait_idle();

        check("st_q_empty", st_q.size(), 0);
        check("kw_q_empty", kw_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
